sub_bytes_seq: RTL

Sequential forward AES SubBytes engine. Accepts a 128-bit state over a valid/ready handshake and substitutes it through `LANES` forward S-box instances, `LANES` bytes per cycle. It returns the substituted state over a second valid/ready handshake. It is the encrypt-direction counterpart of the inverse substitution stage, sized for area-constrained builds where 16 parallel S-boxes are too costly.

---
 rtl/sub_bytes_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sub_bytes_seq.sv
// ============================================================================
// Module      : sub_bytes_seq
// Description : Sequential AES SubBytes engine that substitutes LANES bytes
//               per cycle. Optional inverse substitution with SUBBYTES_INV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] message,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] crypte
`ifdef SUBBYTES_INV_EN
    ,
    input  logic         inv
`endif
);

    localparam int c_n  = 16 / LANES;
    localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_cw-1:0]   r_cnt;
    logic [0:127]      r_data;
    int                w_base;
    logic [7:0]        w_lane_in  [LANES];
    logic [7:0]        w_lane_out [LANES];
`ifdef SUBBYTES_INV_EN
    logic              r_inv;
`endif

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

`ifdef SUBBYTES_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] y;
        y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction
`endif

    assign w_base = int'(r_cnt) * LANES;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_in[l] = r_data[(w_base + l) * 8 +: 8];
`ifdef SUBBYTES_INV_EN
        assign w_lane_out[l] = r_inv ? sbox_inv(w_lane_in[l]) : sbox_fwd(w_lane_in[l]);
`else
        assign w_lane_out[l] = sbox_fwd(w_lane_in[l]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = S_BUSY;
            end
            S_BUSY: begin
                if (r_cnt == c_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Data register is substituted in place, one chunk of LANES bytes per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_data <= '0;
`ifdef SUBBYTES_INV_EN
            r_inv  <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_data <= message;
                r_cnt  <= '0;
`ifdef SUBBYTES_INV_EN
                r_inv  <= inv;
`endif
            end else if (r_state == S_BUSY) begin
                for (int l = 0; l < LANES; l++) begin
                    r_data[(w_base + l) * 8 +: 8] <= w_lane_out[l];
                end
                if (r_cnt != c_last) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign crypte = r_data;

endmodule

`default_nettype wire
